// File: rtl/glitch_cmd_decoder.sv
// Command decoder between the UART receiver and the glitch engine: parses opcode+payload
// frames into the delay/width registers and arm/fire strobes, answering each frame with ACK/NAK.
module glitch_cmd_decoder #(
  parameter int unsigned              DELAY_BYTES   = 2,
  parameter logic [8*DELAY_BYTES-1:0] DEFAULT_DELAY = '0,
  parameter logic [7:0]               DEFAULT_WIDTH = 8'd1,
  parameter int unsigned              TIMEOUT_CLKS  = 500_000,
  parameter logic [7:0]               ACK_BYTE      = 8'h6B,
  parameter logic [7:0]               NAK_BYTE      = 8'h6E
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 data_i,
  input  logic                       data_valid_i,
  output logic [8*DELAY_BYTES-1:0]   delay_o,
  output logic [7:0]                 width_o,
  output logic                       arm_o,
  output logic                       fire_o,
  output logic                       err_o,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i
);

  localparam int unsigned DW  = 8 * DELAY_BYTES;
  localparam int unsigned BCW = $clog2(DELAY_BYTES + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [7:0] OP_DELAY = 8'h64;
  localparam logic [7:0] OP_WIDTH = 8'h77;
  localparam logic [7:0] OP_ARM   = 8'h61;
  localparam logic [7:0] OP_FIRE  = 8'h67;
  localparam logic [7:0] OP_RESET = 8'h72;

  localparam logic [BCW-1:0] CNT_ZERO  = '0;
  localparam logic [BCW-1:0] CNT_ONE   = BCW'(1);
  localparam logic [BCW-1:0] CNT_DELAY = BCW'(DELAY_BYTES);
  localparam logic [TCW-1:0] TMO_ZERO  = '0;
  localparam logic [TCW-1:0] TMO_ONE   = TCW'(1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CLKS - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  state_e           state_q,    state_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic             is_delay_q, is_delay_d;
  logic [DW-1:0]    shreg_q,    shreg_d;
  logic [TCW-1:0]   tmo_cnt_q,  tmo_cnt_d;
  logic [DW-1:0]    delay_q,    delay_d;
  logic [7:0]       width_q,    width_d;
  logic             arm_q,      arm_d;
  logic             fire_q,     fire_d;
  logic             err_q,      err_d;
  logic [7:0]       tx_data_q,  tx_data_d;
  logic             tx_valid_q, tx_valid_d;

  logic             reply_s;
  logic [7:0]       reply_byte_s;
  logic [DW-1:0]    shift_s;
  logic             accept_s;

  // Frame parser: opcode decode, payload collection, inter-byte timeout.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    is_delay_d   = is_delay_q;
    shreg_d      = shreg_q;
    tmo_cnt_d    = tmo_cnt_q;
    delay_d      = delay_q;
    width_d      = width_q;
    arm_d        = 1'b0;
    fire_d       = 1'b0;
    err_d        = 1'b0;
    reply_s      = 1'b0;
    reply_byte_s = ACK_BYTE;
    // Payload is assembled here and committed whole, so delay_o never shows a partial value.
    shift_s      = DW'({shreg_q, data_i});

    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = TMO_ZERO;
        if (data_valid_i) begin
          case (data_i)
            OP_DELAY: begin
              state_d    = ST_PAYLOAD;
              byte_cnt_d = CNT_DELAY;
              is_delay_d = 1'b1;
              shreg_d    = '0;
            end
            OP_WIDTH: begin
              state_d    = ST_PAYLOAD;
              byte_cnt_d = CNT_ONE;
              is_delay_d = 1'b0;
              shreg_d    = '0;
            end
            OP_ARM: begin
              arm_d   = 1'b1;
              reply_s = 1'b1;
            end
            OP_FIRE: begin
              fire_d  = 1'b1;
              reply_s = 1'b1;
            end
            OP_RESET: begin
              delay_d = DEFAULT_DELAY;
              width_d = DEFAULT_WIDTH;
              reply_s = 1'b1;
            end
            default: begin
              err_d        = 1'b1;
              reply_s      = 1'b1;
              reply_byte_s = NAK_BYTE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PAYLOAD: begin
        if (data_valid_i) begin
          tmo_cnt_d = TMO_ZERO;
          shreg_d   = shift_s;
          if (byte_cnt_q == CNT_ONE) begin
            state_d    = ST_IDLE;
            byte_cnt_d = CNT_ZERO;
            reply_s    = 1'b1;
            if (is_delay_q) begin
              delay_d = shift_s;
            end else begin
              width_d = data_i;
            end
          end else begin
            byte_cnt_d = byte_cnt_q - CNT_ONE;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d      = ST_IDLE;
          byte_cnt_d   = CNT_ZERO;
          shreg_d      = '0;
          tmo_cnt_d    = TMO_ZERO;
          err_d        = 1'b1;
          reply_s      = 1'b1;
          reply_byte_s = NAK_BYTE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        byte_cnt_d = CNT_ZERO;
        shreg_d    = '0;
        tmo_cnt_d  = TMO_ZERO;
      end
    endcase
  end

  // Reply slot: a reply arriving while an unaccepted one is pending is dropped.
  always_comb begin
    accept_s   = tx_valid_q & tx_ready_i;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (reply_s && (!tx_valid_q || accept_s)) begin
      tx_data_d  = reply_byte_s;
      tx_valid_d = 1'b1;
    end else if (accept_s) begin
      tx_valid_d = 1'b0;
    end else begin
      tx_valid_d = tx_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= CNT_ZERO;
      is_delay_q <= 1'b0;
      shreg_q    <= '0;
      tmo_cnt_q  <= TMO_ZERO;
      delay_q    <= DEFAULT_DELAY;
      width_q    <= DEFAULT_WIDTH;
      arm_q      <= 1'b0;
      fire_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      is_delay_q <= is_delay_d;
      shreg_q    <= shreg_d;
      tmo_cnt_q  <= tmo_cnt_d;
      delay_q    <= delay_d;
      width_q    <= width_d;
      arm_q      <= arm_d;
      fire_q     <= fire_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign delay_o    = delay_q;
  assign width_o    = width_q;
  assign arm_o      = arm_q;
  assign fire_o     = fire_q;
  assign err_o      = err_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;

endmodule

// File: tb/tb_glitch_cmd_decoder.sv
// Directed bench for glitch_cmd_decoder: inputs driven on the falling edge, outputs
// sampled on the falling edge after the rising edge that consumed the byte.
module tb_glitch_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_i;
  logic        data_valid_i;
  logic [15:0] delay_o;
  logic [7:0]  width_o;
  logic        arm_o;
  logic        fire_o;
  logic        err_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  glitch_cmd_decoder #(
    .DELAY_BYTES  (2),
    .DEFAULT_DELAY(16'h0000),
    .DEFAULT_WIDTH(8'd1),
    .TIMEOUT_CLKS (16),
    .ACK_BYTE     (8'h6B),
    .NAK_BYTE     (8'h6E)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .data_valid_i(data_valid_i),
    .delay_o     (delay_o),
    .width_o     (width_o),
    .arm_o       (arm_o),
    .fire_o      (fire_o),
    .err_o       (err_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i)
  );

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_i       = b;
    data_valid_i = 1'b1;
    @(negedge clk);
    data_valid_i = 1'b0;
  endtask

  task automatic accept_reply();
    @(negedge clk);
    tx_ready_i = 1'b1;
    @(negedge clk);
    tx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (delay_o !== 16'h0000) begin n_fail++; $display("FAIL reset_delay: got %h want %h", delay_o, 16'h0000); end
    n_checks++; if (width_o !== 8'h01) begin n_fail++; $display("FAIL reset_width: got %h want %h", width_o, 8'h01); end
    n_checks++; if ({arm_o, fire_o, err_o} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {arm_o, fire_o, err_o}); end
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid_o); end
    n_checks++; if (tx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data_o); end
    rst = 1'b0;
  endtask

  task automatic test_delay_cmd();
    send_byte(8'h64);
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL delay_opcode_no_reply: got %b want 0", tx_valid_o); end
    send_byte(8'h12);
    n_checks++; if (delay_o !== 16'h0000) begin n_fail++; $display("FAIL delay_atomic: got %h want 0000", delay_o); end
    send_byte(8'h34);
    n_checks++; if (delay_o !== 16'h1234) begin n_fail++; $display("FAIL delay_commit: got %h want 1234", delay_o); end
    n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h6B) begin n_fail++; $display("FAIL delay_ack: got valid=%b data=%h want 1/6b", tx_valid_o, tx_data_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL delay_no_err: got %b want 0", err_o); end
    accept_reply();
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL delay_ack_accepted: got %b want 0", tx_valid_o); end
  endtask

  task automatic test_ready_stall();
    send_byte(8'h77);
    send_byte(8'h22);
    n_checks++; if (width_o !== 8'h22) begin n_fail++; $display("FAIL stall_width: got %h want 22", width_o); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h6B) begin n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b data=%h want 1/6b", i, tx_valid_o, tx_data_o); end
    end
    accept_reply();
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", tx_valid_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    data_i = 8'h61; data_valid_i = 1'b1;
    @(negedge clk);
    data_i = 8'h67;
    n_checks++; if (arm_o !== 1'b1 || fire_o !== 1'b0) begin n_fail++; $display("FAIL b2b_arm: got arm=%b fire=%b want 1/0", arm_o, fire_o); end
    n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h6B) begin n_fail++; $display("FAIL b2b_first_ack: got valid=%b data=%h want 1/6b", tx_valid_o, tx_data_o); end
    @(negedge clk);
    data_valid_i = 1'b0;
    n_checks++; if (arm_o !== 1'b0 || fire_o !== 1'b1) begin n_fail++; $display("FAIL b2b_fire: got arm=%b fire=%b want 0/1", arm_o, fire_o); end
    @(negedge clk);
    n_checks++; if (fire_o !== 1'b0) begin n_fail++; $display("FAIL b2b_fire_width: got %b want 0", fire_o); end
    accept_reply();
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_second_dropped: got %b want 0", tx_valid_o); end
    @(negedge clk);
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stays_empty: got %b want 0", tx_valid_o); end
  endtask

  task automatic test_unknown_opcode();
    send_byte(8'h61);
    // Unknown byte arrives in the same cycle the pending ACK is accepted.
    @(negedge clk);
    data_i = 8'h55; data_valid_i = 1'b1; tx_ready_i = 1'b1;
    @(negedge clk);
    data_valid_i = 1'b0; tx_ready_i = 1'b0;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL unknown_err: got %b want 1", err_o); end
    n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h6E) begin n_fail++; $display("FAIL unknown_nak: got valid=%b data=%h want 1/6e", tx_valid_o, tx_data_o); end
    n_checks++; if (delay_o !== 16'h1234 || width_o !== 8'h22) begin n_fail++; $display("FAIL unknown_regs: got delay=%h width=%h want 1234/22", delay_o, width_o); end
    @(negedge clk);
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL unknown_err_width: got %b want 0", err_o); end
    accept_reply();
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL unknown_accepted: got %b want 0", tx_valid_o); end
  endtask

  task automatic test_timeout();
    int  wait_cycles;
    bit  seen;
    bit  idle_err;
    seen = 1'b0;
    wait_cycles = 0;
    send_byte(8'h64);
    send_byte(8'hAB);
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (err_o === 1'b1) begin
        seen = 1'b1;
        wait_cycles = i;
      end
    end
    n_checks++; if (!seen || wait_cycles < 15 || wait_cycles > 17) begin n_fail++; $display("FAIL timeout_err: got seen=%b after %0d cycles want 1 after 15..17", seen, wait_cycles); end
    n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h6E) begin n_fail++; $display("FAIL timeout_nak: got valid=%b data=%h want 1/6e", tx_valid_o, tx_data_o); end
    n_checks++; if (delay_o !== 16'h1234) begin n_fail++; $display("FAIL timeout_delay_kept: got %h want 1234", delay_o); end
    @(negedge clk);
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_err_width: got %b want 0", err_o); end
    accept_reply();
    send_byte(8'h77);
    send_byte(8'h09);
    n_checks++; if (width_o !== 8'h09 || delay_o !== 16'h1234) begin n_fail++; $display("FAIL timeout_recover: got width=%h delay=%h want 09/1234", width_o, delay_o); end
    n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h6B) begin n_fail++; $display("FAIL timeout_recover_ack: got valid=%b data=%h want 1/6b", tx_valid_o, tx_data_o); end
    accept_reply();
    idle_err = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (err_o !== 1'b0) idle_err = 1'b1;
    end
    n_checks++; if (idle_err !== 1'b0) begin n_fail++; $display("FAIL idle_no_timeout: got err seen=%b want 0", idle_err); end
  endtask

  task automatic test_restore();
    send_byte(8'h72);
    n_checks++; if (delay_o !== 16'h0000 || width_o !== 8'h01) begin n_fail++; $display("FAIL restore_regs: got delay=%h width=%h want 0000/01", delay_o, width_o); end
    n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h6B) begin n_fail++; $display("FAIL restore_ack: got valid=%b data=%h want 1/6b", tx_valid_o, tx_data_o); end
    accept_reply();
  endtask

  task automatic test_mid_frame_reset();
    send_byte(8'h64);
    send_byte(8'h11);
    send_byte(8'h22);
    n_checks++; if (delay_o !== 16'h1122) begin n_fail++; $display("FAIL mfr_setup: got %h want 1122", delay_o); end
    accept_reply();
    send_byte(8'h64);
    send_byte(8'h77);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (tx_valid_o !== 1'b0 || delay_o !== 16'h0000) begin n_fail++; $display("FAIL mfr_after_reset: got valid=%b delay=%h want 0/0000", tx_valid_o, delay_o); end
    send_byte(8'h77);
    send_byte(8'h05);
    n_checks++; if (width_o !== 8'h05 || delay_o !== 16'h0000) begin n_fail++; $display("FAIL mfr_width: got width=%h delay=%h want 05/0000", width_o, delay_o); end
    n_checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h6B) begin n_fail++; $display("FAIL mfr_ack: got valid=%b data=%h want 1/6b", tx_valid_o, tx_data_o); end
    accept_reply();
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL mfr_single_ack: got %b want 0", tx_valid_o); end
  endtask

  initial begin
    rst          = 1'b1;
    data_i       = 8'h00;
    data_valid_i = 1'b0;
    tx_ready_i   = 1'b0;
    test_reset();
    test_delay_cmd();
    test_ready_stall();
    test_back_to_back();
    test_unknown_opcode();
    test_timeout();
    test_restore();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
